grad_div_sched: RTL



---
 rtl/grad_div_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/grad_div_sched.sv
// grad_div_sched
//   Feeds COUNT numerators sharing a single denominator into an external
//   pipelined signed divider, one per cycle, and collects the quotients.
//   Each issued operand pushes a valid bit and its entry index into a
//   LATENCY-deep tag pipe. The tag leaving the pipe decides which result
//   slot takes the divider output.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             job request, accepted only while idle
//   nums_i            packed numerators, entry k at [k*WIDTH +: WIDTH]
//   den_i             shared signed denominator
//   busy              high from the cycle after acceptance through done
//   done              one-cycle pulse when all results are final
//   den_zero          latched at acceptance: denominator was zero
//   div_num, div_den  operands presented to the divider
//   div_quot          quotient returned by the divider
//   res_o             packed quotients, same entry order as nums_i
//
// state   | meaning
// S_IDLE  | waiting for start; divider fed 0/1
// S_ISSUE | presenting entry r_idx to the divider
// S_DRAIN | all entries issued, waiting for the last tag to capture
// S_DONE  | done pulse; back to idle next cycle
module grad_div_sched #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 5,
  parameter int COUNT   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [COUNT*WIDTH-1:0]   nums_i,
  input  logic [WIDTH-1:0]         den_i,
  output logic                     busy,
  output logic                     done,
  output logic                     den_zero,
  output logic [WIDTH-1:0]         div_num,
  output logic [WIDTH-1:0]         div_den,
  input  logic [WIDTH-1:0]         div_quot,
  output logic [COUNT*WIDTH-1:0]   res_o
);

  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;
  // Tag arrays keep one entry even when LATENCY is 0 so declarations stay legal.
  localparam int TD = (LATENCY > 0) ? LATENCY : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_den_zero;
  logic [WIDTH-1:0] r_div_num;
  logic [WIDTH-1:0] r_div_den;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_nums [COUNT];
  logic [WIDTH-1:0] r_res  [COUNT];
  logic             r_tag_v [TD];
  logic [IW-1:0]    r_tag_k [TD];

  logic             w_issue;
  logic             w_accept;
  logic             w_cap_v;
  logic [IW-1:0]    w_cap_k;
  logic [IW-1:0]    w_next_idx;

  assign w_issue    = (r_state == S_ISSUE);
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_next_idx = r_idx + 1'b1;

  // With no divider latency the quotient is captured in the issue cycle itself.
  generate
    if (LATENCY == 0) begin : g_nolat
      assign w_cap_v = w_issue;
      assign w_cap_k = r_idx;
    end else begin : g_lat
      assign w_cap_v = r_tag_v[LATENCY-1];
      assign w_cap_k = r_tag_k[LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_den_zero <= 1'b0;
      r_div_num  <= '0;
      r_div_den  <= WIDTH'(1);
      r_idx      <= '0;
      for (int k = 0; k < COUNT; k++) r_nums[k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < COUNT; k++) r_nums[k] <= nums_i[k*WIDTH +: WIDTH];
            r_den_zero <= (den_i == '0);
            r_div_num  <= nums_i[WIDTH-1:0];
            r_div_den  <= den_i;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_idx == LAST_IDX) begin
            // Park the divider on a safe 0/1 pair once the last entry is out.
            r_div_num <= '0;
            r_div_den <= WIDTH'(1);
            if (LATENCY == 0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_idx     <= w_next_idx;
            r_div_num <= r_nums[w_next_idx];
          end
        end
        S_DRAIN: begin
          if (w_cap_v && (w_cap_k == LAST_IDX)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag pipe and result capture. Reset empties the tag pipe, so quotients
  // still in flight inside the divider are never written after a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TD; i++) begin
        r_tag_v[i] <= 1'b0;
        r_tag_k[i] <= '0;
      end
      for (int k = 0; k < COUNT; k++) r_res[k] <= '0;
    end else begin
      r_tag_v[0] <= w_issue;
      r_tag_k[0] <= r_idx;
      for (int i = 1; i < TD; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_k[i] <= r_tag_k[i-1];
      end
      if (w_accept) begin
        for (int k = 0; k < COUNT; k++) r_res[k] <= '0;
      end else if (w_cap_v) begin
        r_res[w_cap_k] <= r_den_zero ? '0 : div_quot;
      end
    end
  end

  generate
    for (genvar k = 0; k < COUNT; k++) begin : g_res
      assign res_o[k*WIDTH +: WIDTH] = r_res[k];
    end
  endgenerate

  assign busy     = r_busy;
  assign done     = r_done;
  assign den_zero = r_den_zero;
  assign div_num  = r_div_num;
  assign div_den  = r_div_den;

endmodule
